// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results in per-source FIFOs and issues at most one
// register file write per cycle, LSU first, with a starvation guard for the ALU.
module wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                             clk,
    input  logic                             res,
    input  logic                             alu_valid,
    output logic                             alu_ready,
    input  logic [4:0]                       alu_rd,
    input  logic [31:0]                      alu_data,
    input  logic                             lsu_valid,
    output logic                             lsu_ready,
    input  logic [4:0]                       lsu_rd,
    input  logic [31:0]                      lsu_data,
    output logic [4:0]                       wb_rd,
    output logic [31:0]                      wb_data,
    output logic                             wb_valid,
    output logic [$clog2(2*DEPTH+1)-1:0]     pending
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(2 * DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [4:0]    r_alu_rd_mem   [DEPTH];
    logic [31:0]   r_alu_data_mem [DEPTH];
    logic [4:0]    r_lsu_rd_mem   [DEPTH];
    logic [31:0]   r_lsu_data_mem [DEPTH];

    logic [AW-1:0] r_alu_wp, r_alu_rp, r_lsu_wp, r_lsu_rp;
    logic [CW-1:0] r_alu_cnt, r_lsu_cnt;
    logic [CW-1:0] w_alu_cnt_d, w_lsu_cnt_d;
    logic [SW-1:0] r_starve, w_starve_d;
    logic [PW-1:0] r_pending;

    logic          r_wb_valid;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;

    logic w_alu_push, w_lsu_push;
    logic w_alu_ne, w_lsu_ne;
    logic w_alu_win, w_lsu_win;

    // Ready looks only at registered occupancy; no bypass when the head pops this cycle.
    assign alu_ready = (r_alu_cnt != FULL) && res;
    assign lsu_ready = (r_lsu_cnt != FULL) && res;

    // Writes to x0 are accepted but never enter the FIFO.
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign w_lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    assign w_alu_ne  = (r_alu_cnt != '0);
    assign w_lsu_ne  = (r_lsu_cnt != '0);
    assign w_alu_win = w_alu_ne && (!w_lsu_ne || (r_starve == SMAX));
    assign w_lsu_win = w_lsu_ne && !w_alu_win;

    always_comb begin
        w_alu_cnt_d = r_alu_cnt;
        if (w_alu_push && !w_alu_win) begin
            w_alu_cnt_d = r_alu_cnt + CW'(1);
        end else if (!w_alu_push && w_alu_win) begin
            w_alu_cnt_d = r_alu_cnt - CW'(1);
        end

        w_lsu_cnt_d = r_lsu_cnt;
        if (w_lsu_push && !w_lsu_win) begin
            w_lsu_cnt_d = r_lsu_cnt + CW'(1);
        end else if (!w_lsu_push && w_lsu_win) begin
            w_lsu_cnt_d = r_lsu_cnt - CW'(1);
        end

        w_starve_d = '0;
        if (w_alu_ne && w_lsu_win) begin
            w_starve_d = (r_starve == SMAX) ? r_starve : r_starve + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_alu_rd_mem[r_alu_wp]   <= alu_rd;
            r_alu_data_mem[r_alu_wp] <= alu_data;
        end
        if (w_lsu_push) begin
            r_lsu_rd_mem[r_lsu_wp]   <= lsu_rd;
            r_lsu_data_mem[r_lsu_wp] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_alu_wp   <= '0;
            r_alu_rp   <= '0;
            r_lsu_wp   <= '0;
            r_lsu_rp   <= '0;
            r_alu_cnt  <= '0;
            r_lsu_cnt  <= '0;
            r_starve   <= '0;
            r_pending  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            if (w_alu_push) r_alu_wp <= r_alu_wp + AW'(1);
            if (w_lsu_push) r_lsu_wp <= r_lsu_wp + AW'(1);
            if (w_alu_win)  r_alu_rp <= r_alu_rp + AW'(1);
            if (w_lsu_win)  r_lsu_rp <= r_lsu_rp + AW'(1);
            r_alu_cnt  <= w_alu_cnt_d;
            r_lsu_cnt  <= w_lsu_cnt_d;
            r_starve   <= w_starve_d;
            r_pending  <= PW'(w_alu_cnt_d) + PW'(w_lsu_cnt_d);
            r_wb_valid <= w_alu_win || w_lsu_win;
            // wb_data holds its last value on idle cycles; only rd is forced to x0.
            if (w_alu_win) begin
                r_wb_rd   <= r_alu_rd_mem[r_alu_rp];
                r_wb_data <= r_alu_data_mem[r_alu_rp];
            end else if (w_lsu_win) begin
                r_wb_rd   <= r_lsu_rd_mem[r_lsu_rp];
                r_wb_data <= r_lsu_data_mem[r_lsu_rp];
            end else begin
                r_wb_rd   <= 5'd0;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign pending  = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table plus hand-written sequences for
// starvation, back-pressure and asynchronous reset.
module tb_wb_arbiter;

    logic        clk;
    logic        res;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [2:0]  pending;

    int n_cmp;
    int n_bad;

    wb_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (3)
    ) u_dut (
        .clk       (clk),
        .res       (res),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_valid  (wb_valid),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [2:0]  epend;
        logic        ear;
        logic        elr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then return 1 time unit after the next rising edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string name, input logic ev, input logic [4:0] erd,
                          input logic [31:0] edata);
        chk({name, ".wb_valid"}, 32'(wb_valid), 32'(ev));
        chk({name, ".wb_rd"}, 32'(wb_rd), 32'(erd));
        chk({name, ".wb_data"}, wb_data, edata);
    endtask

    vec_t vecs[14];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        res       = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        lsu_valid = 1'b0;
        lsu_rd    = 5'd0;
        lsu_data  = 32'd0;

        //        av ard    ad             lv lrd   ld             ev erd  edata          pend ar lr
        vecs[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        3'd0, 1, 1};
        vecs[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        3'd1, 1, 1};
        vecs[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 3'd0, 1, 1};
        vecs[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'hDEADBEEF, 3'd0, 1, 1};
        vecs[4]  = '{1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,        0, 5'd0, 32'hDEADBEEF, 3'd0, 1, 1};
        vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'hDEADBEEF, 3'd0, 1, 1};
        vecs[6]  = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44,       0, 5'd0, 32'hDEADBEEF, 3'd2, 1, 1};
        vecs[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd4, 32'h44,       3'd1, 1, 1};
        vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd3, 32'h33,       3'd0, 1, 1};
        vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h33,       3'd0, 1, 1};
        vecs[10] = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h77,       0, 5'd0, 32'h33,       3'd1, 1, 1};
        vecs[11] = '{0, 5'd0, 32'h0,        1, 5'd8, 32'h88,       1, 5'd7, 32'h77,       3'd1, 1, 1};
        vecs[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd8, 32'h88,       3'd0, 1, 1};
        vecs[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h88,       3'd0, 1, 1};

        // Reset state while res is held low.
        repeat (2) @(posedge clk);
        #1;
        chk_wb("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.alu_ready", 32'(alu_ready), 32'd0);
        chk("reset.lsu_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        res = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            chk_wb($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erd, vecs[i].edata);
            chk($sformatf("vec%0d.pending", i), 32'(pending), 32'(vecs[i].epend));
            chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
            chk($sformatf("vec%0d.lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].elr));
        end

        // Starvation guard: LSU kept busy, ALU forced through on its 4th contention cycle.
        step(1, 5'd1, 32'h201, 1, 5'd10, 32'h110);
        chk("starve.e1.pending", 32'(pending), 32'd2);
        step(1, 5'd2, 32'h202, 1, 5'd11, 32'h111);
        chk_wb("starve.e2", 1'b1, 5'd10, 32'h110);
        step(0, 5'd0, 32'h0, 1, 5'd12, 32'h112);
        chk_wb("starve.e3", 1'b1, 5'd11, 32'h111);
        step(0, 5'd0, 32'h0, 1, 5'd13, 32'h113);
        chk_wb("starve.e4", 1'b1, 5'd12, 32'h112);
        step(0, 5'd0, 32'h0, 1, 5'd14, 32'h114);
        chk_wb("starve.e5", 1'b1, 5'd1, 32'h201);
        chk("starve.e5.pending", 32'(pending), 32'd3);
        chk("starve.e5.lsu_ready", 32'(lsu_ready), 32'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk_wb("starve.e6", 1'b1, 5'd13, 32'h113);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk_wb("starve.e7", 1'b1, 5'd14, 32'h114);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk_wb("starve.e8", 1'b1, 5'd2, 32'h202);
        chk("starve.e8.pending", 32'(pending), 32'd0);

        // Back-pressure: LSU holds the port once so the ALU FIFO fills.
        step(1, 5'd20, 32'h320, 1, 5'd24, 32'h424);
        step(1, 5'd21, 32'h321, 0, 5'd0, 32'h0);
        chk_wb("bp.g2", 1'b1, 5'd24, 32'h424);
        chk("bp.g2.alu_ready", 32'(alu_ready), 32'd0);
        chk("bp.g2.pending", 32'(pending), 32'd2);
        step(1, 5'd22, 32'h322, 0, 5'd0, 32'h0);
        chk_wb("bp.g3", 1'b1, 5'd20, 32'h320);
        chk("bp.g3.alu_ready", 32'(alu_ready), 32'd1);
        step(1, 5'd22, 32'h322, 0, 5'd0, 32'h0);
        chk_wb("bp.g4", 1'b1, 5'd21, 32'h321);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk_wb("bp.g5", 1'b1, 5'd22, 32'h322);
        chk("bp.g5.pending", 32'(pending), 32'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk_wb("bp.g6", 1'b0, 5'd0, 32'h322);

        // Asynchronous reset with three entries buffered.
        step(1, 5'd30, 32'h530, 1, 5'd9, 32'h609);
        step(1, 5'd31, 32'h531, 1, 5'd6, 32'h606);
        chk_wb("areset.h2", 1'b1, 5'd9, 32'h609);
        chk("areset.h2.pending", 32'(pending), 32'd3);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        res = 1'b0;
        #1;
        chk_wb("areset.async", 1'b0, 5'd0, 32'h0);
        chk("areset.async.pending", 32'(pending), 32'd0);
        chk("areset.async.alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        res = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            chk($sformatf("areset.post%0d.wb_valid", k), 32'(wb_valid), 32'd0);
            chk($sformatf("areset.post%0d.pending", k), 32'(pending), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
